// File: rtl/rca_pipe_param.sv
// rca_pipe_param: pipelined ripple-carry adder/subtractor, CHUNK result bits per stage.
// Define RCA_PIPE_OVF_EN to add the registered signed-overflow output ovf.
module rca_pipe_param #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef RCA_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NSTAGE = WIDTH / CHUNK;

  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : gen_param_check
    $error("rca_pipe_param: WIDTH must be >= 1 and an integer multiple of CHUNK");
  end

  // Inter-stage views: index 0 is the input register, index k+1 is the register of stage k.
  // w_x holds {finished sum bits, unconsumed operand A bits}; w_b holds unconsumed effective B.
  logic [WIDTH-1:0] w_x     [0:NSTAGE];
  logic [WIDTH-1:0] w_b     [0:NSTAGE-1];
  logic             w_c     [0:NSTAGE];
  logic             w_v     [0:NSTAGE];
  logic [CHUNK:0]   w_chunk [0:NSTAGE-1];
  logic             w_stall;

  logic             r_v_in;
  logic             r_c_in;
  logic [WIDTH-1:0] r_x_in;
  logic [WIDTH-1:0] r_b_in;
  logic             r_out_valid;
  logic             r_cout;
  logic [WIDTH-1:0] r_sum;

  assign w_stall  = r_out_valid && !out_ready;
  assign in_ready = !w_stall;

  // Input register: B and carry-in are inverted here so every stage is a plain adder.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v_in <= 1'b0;
      r_c_in <= 1'b0;
      r_x_in <= '0;
      r_b_in <= '0;
    end else if (!w_stall) begin
      r_v_in <= in_valid;
      r_c_in <= sub ? ~cin : cin;
      r_x_in <= a;
      r_b_in <= sub ? ~b : b;
    end
  end

  assign w_x[0] = r_x_in;
  assign w_b[0] = r_b_in;
  assign w_c[0] = r_c_in;
  assign w_v[0] = r_v_in;

  for (genvar k = 0; k < NSTAGE; k++) begin : gen_stage
    logic [WIDTH-1:0] r_x;
    logic             r_c;
    logic             r_v;

    assign w_chunk[k] = {1'b0, w_x[k][CHUNK-1:0]} + {1'b0, w_b[k][CHUNK-1:0]}
                      + (CHUNK+1)'(w_c[k]);

    // Consumed A bits shift out at the bottom while the new sum slice enters at the top.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_x <= '0;
        r_c <= 1'b0;
        r_v <= 1'b0;
      end else if (!w_stall) begin
        r_x <= (w_x[k] >> CHUNK) | (WIDTH'(w_chunk[k][CHUNK-1:0]) << (WIDTH - CHUNK));
        r_c <= w_chunk[k][CHUNK];
        r_v <= w_v[k];
      end
    end

    assign w_x[k+1] = r_x;
    assign w_c[k+1] = r_c;
    assign w_v[k+1] = r_v;

    if (k + 1 < NSTAGE) begin : gen_fwd
      localparam int unsigned BW = WIDTH - (k + 1) * CHUNK;
      logic [BW-1:0] r_b;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_b <= '0;
        end else if (!w_stall) begin
          r_b <= BW'(w_b[k] >> CHUNK);
        end
      end

      assign w_b[k+1] = WIDTH'(r_b);
    end
  end

  // Output register: held while the consumer stalls so sum/cout stay stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_cout      <= 1'b0;
      r_sum       <= '0;
    end else if (!w_stall) begin
      r_out_valid <= w_v[NSTAGE];
      r_cout      <= w_c[NSTAGE];
      r_sum       <= w_x[NSTAGE];
    end
  end

  assign out_valid = r_out_valid;
  assign cout      = r_cout;
  assign sum       = r_sum;

`ifdef RCA_PIPE_OVF_EN
  logic w_ovf_nxt;
  logic r_ovf_stg;
  logic r_ovf;

  // Carry into the MSB is recovered as a ^ b ^ s at that bit; XOR with the carry out.
  assign w_ovf_nxt = w_x[NSTAGE-1][CHUNK-1] ^ w_b[NSTAGE-1][CHUNK-1]
                   ^ w_chunk[NSTAGE-1][CHUNK-1] ^ w_chunk[NSTAGE-1][CHUNK];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf_stg <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (!w_stall) begin
      r_ovf_stg <= w_ovf_nxt;
      r_ovf     <= r_ovf_stg;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule
